// File: rtl/vmem_resp_scratch.sv
// Scratchpad responder for the vector memory unit: line-wide loads and stores, in-order tagged load responses.
// Build option: define VMEM_RESP_STALL_EN to add LFSR-driven stalls on the response head.
module vmem_resp_scratch #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REQ_DATA_WIDTH = 256,
    parameter int TICKET_BITS    = 4,
    parameter int LINES          = 64,
    parameter int LATENCY        = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                      req_we_i,
    input  logic [REQ_DATA_WIDTH-1:0] req_data_i,
    input  logic [TICKET_BITS-1:0]    req_ticket_i,
    output logic                      cache_ready_o,
    output logic                      mem_resp_valid_o,
    output logic [REQ_DATA_WIDTH-1:0] resp_data_o,
    output logic [TICKET_BITS-1:0]    resp_ticket_o,
    output logic                      idle_o
);
    localparam int OFS   = $clog2(REQ_DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(LINES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NPIPE = LATENCY - 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Handshake: a request transfers on a rising edge where mem_req_valid_i && cache_ready_o;
    // each load answers with a one-cycle mem_resp_valid_o pulse, and the response side has no backpressure.
    logic                      accept, ld_acc, st_acc;
    logic [IDX_W-1:0]          idx;
    logic                      unused_addr;
    logic [CNT_W-1:0]          outs;
    logic                      push, pop, empty, hold;
    logic [REQ_DATA_WIDTH-1:0] push_data;
    logic [TICKET_BITS-1:0]    push_ticket;
    logic [CNT_W-1:0]          wr_ptr, rd_ptr;
    logic [REQ_DATA_WIDTH-1:0] mem [LINES];
    logic [REQ_DATA_WIDTH-1:0] fd  [FIFO_DEPTH];
    logic [TICKET_BITS-1:0]    ft  [FIFO_DEPTH];

    assign idx         = req_addr_i[OFS +: IDX_W];
    assign unused_addr = ^req_addr_i;
    assign accept      = mem_req_valid_i && cache_ready_o;
    assign ld_acc      = accept && !req_we_i;
    assign st_acc      = accept && req_we_i;

    // Scratchpad is deliberately not reset; stores survive a reset.
    always_ff @(posedge clk) begin
        if (rst_n && st_acc) mem[idx] <= req_data_i;
    end

    generate
        if (NPIPE > 0) begin : g_pipe
            logic [NPIPE-1:0]          pv;
            logic [REQ_DATA_WIDTH-1:0] pd [NPIPE];
            logic [TICKET_BITS-1:0]    pt [NPIPE];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pv <= '0;
                end else begin
                    pv[0] <= ld_acc;
                    for (int i = 1; i < NPIPE; i++) pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (ld_acc) begin
                    pd[0] <= mem[idx];
                    pt[0] <= req_ticket_i;
                end
                for (int i = 1; i < NPIPE; i++) begin
                    pd[i] <= pd[i-1];
                    pt[i] <= pt[i-1];
                end
            end

            assign push        = pv[NPIPE-1];
            assign push_data   = pd[NPIPE-1];
            assign push_ticket = pt[NPIPE-1];
        end else begin : g_nopipe
            assign push        = ld_acc;
            assign push_data   = mem[idx];
            assign push_ticket = req_ticket_i;
        end
    endgenerate

`ifdef VMEM_RESP_STALL_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign hold = (lfsr[1:0] == 2'b00);
`else
    assign hold = 1'b0;
`endif

    // outs bounds pipe plus FIFO occupancy, so the FIFO never needs a full check.
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = !empty && !hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_ONE;
            if (pop)  rd_ptr <= rd_ptr + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fd[wr_ptr[PTR_W-1:0]] <= push_data;
            ft[wr_ptr[PTR_W-1:0]] <= push_ticket;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)               outs <= '0;
        else if (ld_acc && !pop)  outs <= outs + CNT_ONE;
        else if (!ld_acc && pop)  outs <= outs - CNT_ONE;
    end

    assign cache_ready_o    = (outs != CNT_FULL);
    assign idle_o           = (outs == '0);
    assign mem_resp_valid_o = pop;
    assign resp_data_o      = pop ? fd[rd_ptr[PTR_W-1:0]] : '0;
    assign resp_ticket_o    = pop ? ft[rd_ptr[PTR_W-1:0]] : '0;
endmodule

// File: tb/tb_vmem_resp_scratch.sv
// Scoreboard bench for vmem_resp_scratch: directed loads/stores, expected responses queued at issue, checked by a monitor.
module tb_vmem_resp_scratch;
    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int TW    = 4;
    localparam int LINES = 64;
    localparam int LAT   = 5;
    localparam int FD    = 4;
    localparam int OFS   = 5;
    localparam int EW    = TW + DW;
`ifdef VMEM_RESP_STALL_EN
    localparam int N_RAND = 200;
`else
    localparam int N_RAND = 60;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req_valid_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_we_i = 1'b0;
    logic [DW-1:0] req_data_i = '0;
    logic [TW-1:0] req_ticket_i = '0;
    logic          cache_ready_o, mem_resp_valid_o, idle_o;
    logic [DW-1:0] resp_data_o;
    logic [TW-1:0] resp_ticket_o;

    logic [DW-1:0] model_mem [LINES];
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [EW-1:0] mon_e;
    int            mon_c;
    int            cyc = 0;
    int            m_outs = 0;
    int            n_vec = 0;
    int            n_fail = 0;

    vmem_resp_scratch #(
        .ADDR_WIDTH(AW), .REQ_DATA_WIDTH(DW), .TICKET_BITS(TW),
        .LINES(LINES), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid_i(mem_req_valid_i), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_data_i(req_data_i), .req_ticket_i(req_ticket_i),
        .cache_ready_o(cache_ready_o), .mem_resp_valid_o(mem_resp_valid_o),
        .resp_data_o(resp_data_o), .resp_ticket_o(resp_ticket_o), .idle_o(idle_o)
    );

    // clock / reset / cycle counter / outstanding-load model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (!rst_n) m_outs <= 0;
        else m_outs <= m_outs + ((mem_req_valid_i && !req_we_i && m_outs != FD) ? 1 : 0)
                              - (mem_resp_valid_o ? 1 : 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", cache_ready_o, m_outs != FD);
            check("idle", idle_o, m_outs == 0);
            if (mem_resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got ticket %0d at cycle %0d, required no response",
                             resp_ticket_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    check("resp_ticket", resp_ticket_o, mon_e[EW-1:DW]);
                    check("resp_data", resp_data_o, mon_e[DW-1:0]);
`ifdef VMEM_RESP_STALL_EN
                    check("resp_not_early", cyc >= mon_c, 1'b1);
`else
                    check("resp_cycle", cyc, mon_c);
`endif
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [TW-1:0] tk);
        int waited = 0;
        logic [5:0] li;
        li = addr[OFS +: 6];
        mem_req_valid_i = 1'b1;
        req_we_i        = we;
        req_addr_i      = addr;
        req_data_i      = data;
        req_ticket_i    = tk;
        while (m_outs == FD && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (m_outs == FD) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: ready still low after %0d cycles, required accept", waited);
            mem_req_valid_i = 1'b0;
            return;
        end
        if (we) model_mem[li] = data;
        else begin
            exp_q.push_back({tk, model_mem[li]});
            exp_cyc_q.push_back(cyc + LAT);
        end
        @(posedge clk); #1;
        mem_req_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [31:0]   w;
        logic [DW-1:0] line_x, line_y;
        int            waited;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_valid", mem_resp_valid_o, 1'b0);
        check("rst_data", resp_data_o, '0);
        check("rst_ticket", resp_ticket_o, '0);
        check("rst_ready", cache_ready_o, 1'b1);
        check("rst_idle", idle_o, 1'b1);

        // store then load the same line
        issue(1'b1, 32'h40, {32{8'hAA}}, 4'd1);
        issue(1'b0, 32'h40, '0, 4'd3);
        idle_cycles(10);

        // four back-to-back loads fill the outstanding budget
        for (int i = 1; i <= 4; i++) begin
            w = 32'h1111_0000 + i;
            issue(1'b1, i * 32, {8{w}}, 4'd0);
        end
        for (int i = 1; i <= 4; i++) issue(1'b0, i * 32, '0, TW'(i - 1));
        check("full_ready_low", cache_ready_o, 1'b0);
        check("full_not_idle", idle_o, 1'b0);
        idle_cycles(12);

        // address alias modulo LINES
        issue(1'b1, 32'h0, {16{16'hC0DE}}, 4'd0);
        issue(1'b0, 32'h800, '0, 4'd6);
        idle_cycles(10);

        // reset with a load in flight: no response, stores kept
        issue(1'b0, 32'h40, '0, 4'd5);
        idle_cycles(1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        check("midrst_ready", cache_ready_o, 1'b1);
        check("midrst_idle", idle_o, 1'b1);
        check("midrst_valid", mem_resp_valid_o, 1'b0);
        idle_cycles(10);
        issue(1'b0, 32'h40, '0, 4'd7);
        idle_cycles(10);

        // load, overwrite on the next cycle, load again
        line_x = {8{32'hDEAD_0007}};
        line_y = {8{32'h5EED_0007}};
        issue(1'b1, 7 * 32, line_x, 4'd0);
        issue(1'b0, 7 * 32, '0, 4'd8);
        issue(1'b1, 7 * 32, line_y, 4'd0);
        issue(1'b0, 7 * 32 + 5, '0, 4'd9);
        idle_cycles(10);

        // fill every line, then a mixed load/store run with arbitrary upper/lower address bits
        for (int i = 0; i < LINES; i++) issue(1'b1, i * 32, rand_line(), 4'd0);
        for (int n = 0; n < N_RAND; n++) begin
            issue($urandom_range(0, 2) == 0, $urandom, rand_line(), TW'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_left", exp_q.size(), 0);
        idle_cycles(3);
        check("end_idle", idle_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
